// File: rtl/ap_pkg.sv
// Shared opcode, tag-mode and drain-state encodings for the associative-processor array.
package ap_pkg;

  localparam int unsigned AP_OP_W     = 3;
  localparam int unsigned AP_TM_W     = 2;
  localparam int unsigned AP_MAX_ROWS = 256;

  typedef enum logic [AP_OP_W-1:0] {
    AP_NOP      = 3'd0,
    AP_LOAD     = 3'd1,
    AP_COMPARE  = 3'd2,
    AP_WRITE    = 3'd3,
    AP_SET_TAGS = 3'd4,
    AP_CLR_TAGS = 3'd5,
    AP_DRAIN    = 3'd6,
    AP_RSVD     = 3'd7
  } ap_op_e;

  typedef enum logic [AP_TM_W-1:0] {
    TM_REPLACE = 2'd0,
    TM_AND     = 2'd1,
    TM_OR      = 2'd2,
    TM_RSVD    = 2'd3
  } ap_tmode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } ap_state_e;

  // Tag vectors up to AP_MAX_ROWS wide are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [AP_MAX_ROWS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < AP_MAX_ROWS; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/ap_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module ap_prio_enc #(
  parameter  int unsigned N     = 16,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/ap_cam_array.sv
// Associative-processor storage array: masked compare/write over tagged rows,
// direct row load, and a streaming drain of tagged rows lowest index first.
module ap_cam_array
  import ap_pkg::*;
#(
  parameter  int unsigned ROWS  = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned ROW_W = $clog2(ROWS),
  localparam int unsigned CNT_W = $clog2(ROWS + 1)
) (
  input  logic             clk,
  input  logic             rstIn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_tmode,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [WIDTH-1:0] cmd_key,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic [ROWS-1:0]  tag,
  output logic             tag_any,
  output logic [CNT_W-1:0] tag_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [WIDTH-1:0] out_data,
  output logic             drain_done
);

  logic [WIDTH-1:0] mem_q [ROWS];
  logic [ROWS-1:0]  tag_q, tag_d;
  logic [ROWS-1:0]  match;
  ap_state_e        state_q, state_d;
  logic             rdy_q;
  logic [ROW_W-1:0] low_idx;
  logic             low_any;
  logic             cmd_fire, out_fire;
  ap_op_e           op;
  ap_tmode_e        tmode;

  assign op    = ap_op_e'(cmd_op);
  assign tmode = ap_tmode_e'(cmd_tmode);

  ap_prio_enc #(.N(ROWS)) u_prio_enc (
    .req (tag_q),
    .idx (low_idx),
    .any (low_any)
  );

  // rdy_q keeps cmd_ready low through reset and for the cycle it is released.
  assign cmd_ready  = rdy_q && (state_q == ST_IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign out_valid  = (state_q == ST_DRAIN) && low_any;
  assign out_fire   = out_valid && out_ready;
  assign out_row    = low_idx;
  assign out_data   = mem_q[low_idx];
  assign drain_done = (state_q == ST_DONE);
  assign tag        = tag_q;
  assign tag_any    = low_any;
  assign tag_count  = CNT_W'(popcount(AP_MAX_ROWS'(tag_q)));

  // Masked-out columns always count as matching.
  always_comb begin
    match = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      match[r] = &(~(mem_q[r] ^ cmd_key) | ~cmd_mask);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_fire && (op == AP_DRAIN)) state_d = ST_DRAIN;
      ST_DRAIN: if (!low_any) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_d = tag_q;
    if (cmd_fire) begin
      case (op)
        AP_COMPARE: begin
          case (tmode)
            TM_AND:  tag_d = tag_q & match;
            TM_OR:   tag_d = tag_q | match;
            default: tag_d = match;
          endcase
        end
        AP_SET_TAGS: tag_d = '1;
        AP_CLR_TAGS: tag_d = '0;
        default:     tag_d = tag_q;
      endcase
    end
    if (out_fire) tag_d[low_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rstIn) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      rdy_q   <= 1'b1;
    end
  end

  // Array contents only change on accepted LOAD/WRITE, so they are frozen while draining.
  always_ff @(posedge clk) begin
    if (rstIn) begin
      for (int unsigned r = 0; r < ROWS; r++) mem_q[r] <= '0;
    end else if (cmd_fire) begin
      case (op)
        AP_LOAD: begin
          if (int'(cmd_row) < int'(ROWS)) mem_q[cmd_row] <= cmd_key;
        end
        AP_WRITE: begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            if (tag_q[r]) mem_q[r] <= (mem_q[r] & ~cmd_mask) | (cmd_key & cmd_mask);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
